uart_cpld_fifo: RTL

Synthesisable, parametrised successor to the CPLD UART bus model. It presents the same `uart_rdn`/`uart_wrn`/`uart_dataready`/`uart_tbre`/`uart_tsre` bus handshake to the CPU-side bus controller, and drives a real serial TX/RX pair. Compared with the single-byte model, it adds TX and RX FIFOs of configurable depth, a configurable data width and baud divider, start/stop framing checks, and overrun reporting. It sits between the SoC's UART bus controller and the board's serial pins.

---
 rtl/uart_cpld_fifo.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cpld_fifo.sv
// UART bus model with TX/RX FIFOs: CPU-side rdn/wrn strobe handshake in front of
// a real serial TX/RX pair with framing checks and overrun reporting.
module uart_cpld_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TX_DEPTH     = 4,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rdn,
  input  logic              uart_wrn,
  input  logic [DATA_W-1:0] bus_din,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_doe,
  output logic              uart_dataready,
  output logic              uart_tbre,
  output logic              uart_tsre,
  output logic              txd,
  input  logic              rxd,
  output logic              tx_overflow,
  output logic              rx_overrun,
  output logic              rx_frame_err
);

  localparam int unsigned TX_AW    = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW    = $clog2(RX_DEPTH);
  localparam int unsigned TX_PW    = TX_AW + 1;
  localparam int unsigned RX_PW    = RX_AW + 1;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W    = $clog2(DATA_W + 1);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // Synchronisers: stage [1] is the synchronised value, stage [2] the delayed copy for edges
  logic [2:0] rdn_sync;
  logic [2:0] wrn_sync;
  logic [1:0] rxd_sync;
  logic       wr_rise_c;
  logic       rd_fall_c;
  logic       rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_sync <= '1;
      wrn_sync <= '1;
      rxd_sync <= '1;
    end else begin
      rdn_sync <= {rdn_sync[1:0], uart_rdn};
      wrn_sync <= {wrn_sync[1:0], uart_wrn};
      rxd_sync <= {rxd_sync[0], rxd};
    end
  end

  assign wr_rise_c = wrn_sync[1] & ~wrn_sync[2];
  assign rd_fall_c = ~rdn_sync[1] & rdn_sync[2];
  assign rxd_s     = rxd_sync[1];
  assign bus_doe   = ~uart_rdn;

  logic [DATA_W-1:0] wr_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_hold <= '0;
    end else if (!wrn_sync[0]) begin
      wr_hold <= bus_din;
    end
  end

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_PW-1:0]  tx_wr_ptr;
  logic [TX_PW-1:0]  tx_rd_ptr;
  logic              tx_empty_c;
  logic              tx_full_c;
  logic              tx_push_c;
  logic              tx_drop_c;
  logic              tx_pop_c;
  logic [DATA_W-1:0] tx_head_c;

  assign tx_empty_c = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full_c  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                      (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  assign tx_push_c  = wr_rise_c && (!tx_full_c || tx_pop_c);
  assign tx_drop_c  = wr_rise_c && tx_full_c && !tx_pop_c;
  assign tx_head_c  = tx_mem[tx_rd_ptr[TX_AW-1:0]];
  assign uart_tbre  = ~tx_full_c;

  always_ff @(posedge clk) begin
    if (tx_push_c) begin
      tx_mem[tx_wr_ptr[TX_AW-1:0]] <= wr_hold;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
      if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
    end
  end

  // TX FSM
  uart_state_t       tx_state;
  uart_state_t       tx_state_nxt;
  logic [CNT_W-1:0]  tx_clk_cnt;
  logic [BIT_W-1:0]  tx_bit_idx;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_shift_nxt_c;
  logic              tx_bit_end_c;
  logic              tx_last_bit_c;

  assign tx_bit_end_c   = (tx_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign tx_last_bit_c  = (tx_bit_idx == BIT_W'(DATA_W - 1));
  assign tx_shift_nxt_c = tx_shift >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= ST_IDLE;
    else     tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      ST_IDLE:  if (!tx_empty_c)                    tx_state_nxt = ST_START;
      ST_START: if (tx_bit_end_c)                   tx_state_nxt = ST_DATA;
      ST_DATA:  if (tx_bit_end_c && tx_last_bit_c)  tx_state_nxt = ST_STOP;
      ST_STOP:  if (tx_bit_end_c)                   tx_state_nxt = ST_IDLE;
      default:                                      tx_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_pop_c = 1'b0;
    if (tx_state == ST_IDLE && !tx_empty_c) tx_pop_c = 1'b1;
  end

  // TX datapath; tsre looks at the pre-pop FIFO state so it falls with the start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd        <= 1'b1;
      uart_tsre  <= 1'b1;
      tx_shift   <= '0;
      tx_clk_cnt <= '0;
      tx_bit_idx <= '0;
    end else begin
      uart_tsre <= (tx_state_nxt == ST_IDLE) && tx_empty_c;
      if (tx_state == ST_IDLE || tx_bit_end_c) tx_clk_cnt <= '0;
      else                                     tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
      case (tx_state)
        ST_IDLE: begin
          tx_bit_idx <= '0;
          if (tx_pop_c) begin
            tx_shift <= tx_head_c;
            txd      <= 1'b0;
          end else begin
            txd <= 1'b1;
          end
        end
        ST_START: if (tx_bit_end_c) txd <= tx_shift[0];
        ST_DATA: begin
          if (tx_bit_end_c) begin
            tx_shift   <= tx_shift_nxt_c;
            tx_bit_idx <= tx_bit_idx + BIT_W'(1);
            txd        <= tx_last_bit_c ? 1'b1 : tx_shift_nxt_c[0];
          end
        end
        default: txd <= 1'b1;
      endcase
    end
  end

  // RX FIFO
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_PW-1:0]  rx_wr_ptr;
  logic [RX_PW-1:0]  rx_rd_ptr;
  logic              rx_empty_c;
  logic              rx_full_c;
  logic              rx_push_c;
  logic              rx_drop_c;
  logic              rx_pop_c;
  logic              rx_ferr_c;
  logic [DATA_W-1:0] rx_shift;

  assign rx_empty_c     = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full_c      = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                          (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_pop_c       = rd_fall_c && !rx_empty_c;
  assign bus_dout       = rx_empty_c ? '0 : rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign uart_dataready = ~rx_empty_c;

  always_ff @(posedge clk) begin
    if (rx_push_c) begin
      rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push_c) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
      if (rx_pop_c)  rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
    end
  end

  // RX FSM
  uart_state_t      rx_state;
  uart_state_t      rx_state_nxt;
  logic [CNT_W-1:0] rx_clk_cnt;
  logic [BIT_W-1:0] rx_bit_idx;
  logic             rx_wait_hi;
  logic             rx_half_c;
  logic             rx_bit_end_c;
  logic             rx_last_bit_c;
  logic             rx_stop_smp_c;

  assign rx_half_c     = (rx_clk_cnt == CNT_W'(HALF_BIT - 1));
  assign rx_bit_end_c  = (rx_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign rx_last_bit_c = (rx_bit_idx == BIT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= ST_IDLE;
    else     rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      ST_IDLE:  if (!rxd_s && !rx_wait_hi)          rx_state_nxt = ST_START;
      ST_START: if (rx_half_c)                      rx_state_nxt = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_bit_end_c && rx_last_bit_c)  rx_state_nxt = ST_STOP;
      ST_STOP:  if (rx_bit_end_c)                   rx_state_nxt = ST_IDLE;
      default:                                      rx_state_nxt = ST_IDLE;
    endcase
  end

  // A full FIFO still accepts the character when a read frees a slot in the same cycle
  always_comb begin
    rx_stop_smp_c = (rx_state == ST_STOP) && rx_bit_end_c;
    rx_push_c     = rx_stop_smp_c && rxd_s && (!rx_full_c || rx_pop_c);
    rx_drop_c     = rx_stop_smp_c && rxd_s && rx_full_c && !rx_pop_c;
    rx_ferr_c     = rx_stop_smp_c && !rxd_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_clk_cnt <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      rx_wait_hi <= 1'b0;
    end else begin
      if (rx_state == ST_IDLE || (rx_state == ST_START && rx_half_c) ||
          (rx_state != ST_START && rx_bit_end_c)) begin
        rx_clk_cnt <= '0;
      end else begin
        rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
      end
      if (rx_state == ST_IDLE) begin
        rx_bit_idx <= '0;
      end else if (rx_state == ST_DATA && rx_bit_end_c) begin
        rx_shift   <= {rxd_s, rx_shift[DATA_W-1:1]};
        rx_bit_idx <= rx_bit_idx + BIT_W'(1);
      end
      if (rx_ferr_c)  rx_wait_hi <= 1'b1;
      else if (rxd_s) rx_wait_hi <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overflow  <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      tx_overflow  <= tx_drop_c;
      rx_overrun   <= rx_drop_c;
      rx_frame_err <= rx_ferr_c;
    end
  end

endmodule
